// File: rtl/latch_bank_sequencer_pkg.sv
// latch_bank_sequencer_pkg: shared FSM state encoding and pulse counter width
// for the latch bank write sequencer.
package latch_bank_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } lb_state_t;

    // Width of the counter that times the enable pulse (PULSE_CYC up to 15)
    localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/latch_bank_sequencer_arbiter.sv
// lb_arbiter: combinational winner select among write requesters.
// Produces a one-hot grant and the binary winner index.
// Macro LB_RR_EN: rotating priority starting at rr_ptr; when undefined,
// fixed priority with the lowest index winning and no rr_ptr input.
module lb_arbiter
    import latch_bank_sequencer_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
`ifdef LB_RR_EN
    input  logic [PW-1:0]   rr_ptr,
`endif
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   win_idx
);

    logic found;

`ifdef LB_RR_EN
    int idx;

    // Search from rr_ptr upward, wrapping at NREQ; first set request wins
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + int'(i)) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
            end
        end
    end
`else
    // Fixed priority: lowest set index wins
    always_comb begin
        grant   = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                win_idx  = PW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer: arbitrates synchronous write requests and sequences
// them into a bank of level-sensitive latches. D is driven one cycle before
// the enable rises and held one cycle after it falls, so no latch ever sees
// D move while transparent. All outputs come straight from flops.
// Macro LB_RR_EN: round-robin arbitration (otherwise fixed priority).
module latch_bank_sequencer
    import latch_bank_sequencer_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int AW        = 3,
    parameter int PULSE_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      latch_d,
    output logic [DEPTH-1:0]      latch_en,
    output logic                  busy
);

    localparam int PW = $clog2(NREQ);
    localparam logic [DEPTH-1:0] EN_ONE = DEPTH'(1);

    lb_state_t         state;
    logic [CNT_W-1:0]  cnt;
    logic [AW-1:0]     cap_addr;
    logic [NREQ-1:0]   cap_win;
    logic [NREQ-1:0]   grant;
    logic [PW-1:0]     win_idx;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;

`ifdef LB_RR_EN
    logic [PW-1:0]     rr_ptr;
`endif

    lb_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req     (req),
`ifdef LB_RR_EN
        .rr_ptr  (rr_ptr),
`endif
        .grant   (grant),
        .win_idx (win_idx)
    );

    assign sel_addr = req_addr[int'(win_idx)*AW +: AW];
    assign sel_data = req_data[int'(win_idx)*WIDTH +: WIDTH];

    // Write sequencer: capture at grant, setup, enable pulse, hold with ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_addr <= '0;
            cap_win  <= '0;
            latch_d  <= '0;
            latch_en <= '0;
            ack      <= '0;
            busy     <= 1'b0;
`ifdef LB_RR_EN
            rr_ptr   <= '0;
`endif
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        cap_addr <= sel_addr;
                        cap_win  <= grant;
                        latch_d  <= sel_data;
                        busy     <= 1'b1;
                        state    <= SETUP;
`ifdef LB_RR_EN
                        rr_ptr   <= (int'(win_idx) == NREQ - 1) ? '0 : win_idx + 1'b1;
`endif
                    end
                end
                SETUP: begin
                    // Decode lands in the flop so latch_en has no output logic
                    latch_en <= EN_ONE << cap_addr;
                    cnt      <= CNT_W'(PULSE_CYC - 1);
                    state    <= PULSE;
                end
                PULSE: begin
                    if (cnt == '0) begin
                        latch_en <= '0;
                        ack      <= cap_win;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// tb_latch_bank_sequencer: directed and random write traffic against a
// transaction-level timeline model and a behavioural latch array.
module tb_latch_bank_sequencer;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int P     = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [NREQ*AW-1:0]    req_addr = '0;
    logic [NREQ*WIDTH-1:0] req_data = '0;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      latch_d;
    logic [DEPTH-1:0]      latch_en;
    logic                  busy;

    always #5 clk = ~clk;

    latch_bank_sequencer #(
        .NREQ      (NREQ),
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AW        (AW),
        .PULSE_CYC (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .latch_d  (latch_d),
        .latch_en (latch_en),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    // Model state: cycle count, when the controller can next grant, last grant
    int cyc     = 0;
    int idle_at = 0;
    int g_cyc   = -100;
    int g_win   = 0;
`ifdef LB_RR_EN
    int rr      = 0;
`endif
    logic [AW-1:0]    g_addr = '0;
    logic [WIDTH-1:0] g_data = '0;
    logic [WIDTH-1:0] cur_d  = '0;
    logic [WIDTH-1:0] prev_d = '0;
    logic [WIDTH-1:0] mem [DEPTH];
    bit   auto_drop = 1'b0;
    int   ack_q[$];
    int   ack_t[$];
    int   exp_order[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: model grant decision from the inputs now driven, then check
    // the outputs right after the edge.
    task automatic step();
        int w;
        logic [NREQ-1:0]  e_ack;
        logic [DEPTH-1:0] e_en;
        logic             e_busy;
        w = -1;
        if (cyc >= idle_at && req != '0) begin
`ifdef LB_RR_EN
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[(rr + k) % NREQ]) w = (rr + k) % NREQ;
            rr = (w + 1) % NREQ;
`else
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && req[k]) w = k;
`endif
            g_cyc   = cyc;
            g_win   = w;
            g_addr  = req_addr[w*AW +: AW];
            g_data  = req_data[w*WIDTH +: WIDTH];
            cur_d   = g_data;
            idle_at = cyc + 3 + P;
        end
        @(posedge clk);
        #1;
        cyc++;
        e_ack  = (cyc == g_cyc + 2 + P) ? (NREQ'(1) << g_win) : '0;
        e_en   = (cyc >= g_cyc + 2 && cyc <= g_cyc + 1 + P) ? (DEPTH'(1) << g_addr) : '0;
        e_busy = (cyc >= g_cyc + 1 && cyc <= g_cyc + 2 + P);
        chk("ack", ack, e_ack);
        chk("latch_en", latch_en, e_en);
        chk("busy", busy, e_busy);
        chk("latch_d", latch_d, cur_d);
        chk("d_stable_while_en", (|latch_en) && (latch_d !== prev_d), 1'b0);
        chk("en_onehot0", $onehot0(latch_en), 1'b1);
        for (int k = 0; k < DEPTH; k++)
            if (latch_en[k]) mem[k] = latch_d;
        if (e_ack != '0) begin
            chk("mem_write", mem[g_addr], g_data);
            ack_q.push_back(g_win);
            ack_t.push_back(cyc);
        end
        prev_d = latch_d;
        if (auto_drop) req = req & ~ack;
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_latch_en", latch_en, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ack", ack, '0);
        chk("rst_latch_d", latch_d, '0);
        @(posedge clk);
        #1;
        cyc++;
        rst     = 1'b0;
        g_cyc   = -100;
        idle_at = cyc;
        cur_d   = '0;
        prev_d  = '0;
`ifdef LB_RR_EN
        rr      = 0;
`endif
    endtask

    initial begin
        // Power-on reset
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("por_latch_en", latch_en, '0);
        chk("por_ack", ack, '0);
        chk("por_latch_d", latch_d, '0);
        chk("por_busy", busy, 1'b0);
        rst = 1'b0;

        // Single write: requester 0, addr 3, data A5
        auto_drop = 1'b1;
        req_addr[0*AW +: AW]       = 3'd3;
        req_data[0*WIDTH +: WIDTH] = 8'hA5;
        req[0] = 1'b1;
        for (int n = 0; n < 7; n++) step();
        chk("single_ack_n", ack_q.size(), 1);
        if (ack_q.size() > 0) chk("single_ack_who", ack_q[0], 0);
        chk("single_mem3", mem[3], 8'hA5);
        chk("single_req_dropped", req[0], 1'b0);

        // Simultaneous requests from a fresh arbitration state
        async_reset();
        ack_q.delete();
        ack_t.delete();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW]       = AW'(i + 4);
            req_data[i*WIDTH +: WIDTH] = WIDTH'(8'h30 + i);
        end
`ifdef LB_RR_EN
        req = 4'b1111;
        exp_order = '{0, 1, 2, 3};
`else
        req = 4'b0110;
        exp_order = '{1, 2};
`endif
        for (int n = 0; n < 24; n++) step();
        chk("multi_ack_n", ack_q.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < ack_q.size(); i++)
            chk("multi_order", ack_q[i], exp_order[i]);
        for (int i = 1; i < ack_t.size(); i++)
            chk("multi_spacing", ack_t[i] - ack_t[i-1], 3 + P);

        // Data changes after grant are ignored
        req = '0;
        ack_q.delete();
        req_addr[0*AW +: AW]       = 3'd5;
        req_data[0*WIDTH +: WIDTH] = 8'h11;
        req[0] = 1'b1;
        step();
        step();
        req_data[0*WIDTH +: WIDTH] = 8'hFF;
        for (int n = 0; n < 5; n++) step();
        chk("late_data_mem5", mem[5], 8'h11);
        chk("late_data_ack_n", ack_q.size(), 1);

        // Request withdrawn during SETUP still completes
        ack_q.delete();
        req_addr[0*AW +: AW]       = 3'd6;
        req_data[0*WIDTH +: WIDTH] = 8'h3C;
        req[0] = 1'b1;
        step();
        req[0] = 1'b0;
        for (int n = 0; n < 5; n++) step();
        chk("withdraw_ack_n", ack_q.size(), 1);
        if (ack_q.size() > 0) chk("withdraw_ack_who", ack_q[0], 0);
        chk("withdraw_mem6", mem[6], 8'h3C);

        // Reset during PULSE abandons the write; the held request reruns
        ack_q.delete();
        req_addr[1*AW +: AW]       = 3'd2;
        req_data[1*WIDTH +: WIDTH] = 8'h77;
        req[1] = 1'b1;
        step();
        step();
        chk("pre_rst_en", latch_en, 8'b0000_0100);
        async_reset();
        chk("rst_no_ack", ack_q.size(), 0);
        for (int n = 0; n < 6; n++) step();
        chk("post_rst_ack_n", ack_q.size(), 1);
        chk("post_rst_mem2", mem[2], 8'h77);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(3) == 0) begin
                    req[i] = 1'b1;
                    req_addr[i*AW +: AW]       = AW'($urandom);
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end else if (req[i] && $urandom_range(7) == 0) begin
                    req_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
